// File: rtl/vlsu_sequencer.sv
// Vector load/store sequencer: walks agu beat addresses on a 64-bit memory port and returns one VLEN-bit response.
// Optional macro VLSU_PIPELINED_LOAD_EN: back-to-back load beats with returns counted independently.
package vlsu_pkg;
  typedef enum logic [1:0] {
    UNIT_STRIDE = 2'd0,
    STRIDED     = 2'd1,
    INDEXED     = 2'd2,
    SEGMENT     = 2'd3
  } access_e;

  typedef struct packed {
    logic [63:0] base;
    access_e     acc;
  } mem_req_t;
endpackage

module agu #(
  parameter int NBEAT = 4
) (
  input  logic [63:0]             base_i,
  output logic [NBEAT-1:0][63:0]  addresses_o
);
  always_comb begin
    for (int k = 0; k < NBEAT; k++) begin
      addresses_o[k] = base_i + (64'(k) << 3);
    end
  end
endmodule

module vlsu_sequencer
  import vlsu_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int NBEAT = VLEN / 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  mem_req_t        req,
  input  logic            req_store,
  input  logic [VLEN-1:0] req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [63:0]     mem_addr,
  output logic            mem_we,
  output logic [63:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [63:0]     mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [VLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);
  localparam int CW = $clog2(NBEAT) + 1;
  localparam int IW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);
  localparam logic [CW-1:0] FULL = CW'(NBEAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          ibeat_q, ibeat_d, rbeat_q, rbeat_d;
  logic                   err_q, err_d, store_q;
  logic [63:0]            base_q;
  logic [NBEAT-1:0][63:0] wdata_q, rbuf_q, addresses;
  logic                   accept, beat_fire, ret_fire;

  function automatic logic [IW-1:0] slot(input logic [CW-1:0] cnt);
    int unsigned m;
    m = 32'(cnt) % 32'(NBEAT);
    return m[IW-1:0];
  endfunction

  agu #(.NBEAT(NBEAT)) u_agu (
    .base_i      (base_q),
    .addresses_o (addresses)
  );

  always_comb begin
    state_d   = state_q;
    ibeat_d   = ibeat_q;
    rbeat_d   = rbeat_q;
    err_d     = err_q;
    req_ready = (state_q == IDLE);
    accept    = req_valid && req_ready;
    mem_valid = (state_q == ISSUE);
    beat_fire = mem_valid && mem_ready;
`ifdef VLSU_PIPELINED_LOAD_EN
    ret_fire  = mem_rvalid && !store_q && (rbeat_q != FULL) &&
                ((state_q == ISSUE) || (state_q == WAIT));
`else
    ret_fire  = mem_rvalid && !store_q && (rbeat_q != FULL) && (state_q == WAIT);
`endif
    if (beat_fire) ibeat_d = ibeat_q + 1'b1;
    if (ret_fire)  rbeat_d = rbeat_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          ibeat_d = '0;
          rbeat_d = '0;
          err_d   = (req.acc != UNIT_STRIDE);
          state_d = (req.acc != UNIT_STRIDE) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (beat_fire) begin
          if (store_q) begin
            if (ibeat_q == LAST) state_d = RESP;
          end
`ifdef VLSU_PIPELINED_LOAD_EN
          else if (ibeat_q == LAST) begin
            state_d = (rbeat_d == FULL) ? RESP : WAIT;
          end
`else
          else begin
            state_d = WAIT;
          end
`endif
        end
      end
      WAIT: begin
        if (ret_fire) begin
          if (rbeat_d == FULL) state_d = RESP;
`ifndef VLSU_PIPELINED_LOAD_EN
          else state_d = ISSUE;
`endif
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced to zero outside their owning state so they read as reset values when idle.
    mem_we     = mem_valid && store_q;
    mem_addr   = mem_valid ? addresses[slot(ibeat_q)] : '0;
    mem_wdata  = mem_we ? wdata_q[slot(ibeat_q)] : '0;
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = resp_valid ? rbuf_q : '0;
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ibeat_q <= '0;
      rbeat_q <= '0;
      err_q   <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ibeat_q <= ibeat_d;
      rbeat_q <= rbeat_d;
      err_q   <= err_d;
      if (accept) store_q <= req_store;
    end
  end

  // Datapath registers carry no reset; every consumer is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= req.base;
      wdata_q <= req_wdata;
      rbuf_q  <= '0;
    end else if (ret_fire) begin
      rbuf_q[slot(rbeat_q)] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vlsu_sequencer.sv
// Randomized bench for vlsu_sequencer against a transaction-level memory/response model.
`timescale 1ns/1ps
module tb_vlsu_sequencer;
  import vlsu_pkg::*;

  localparam int VLEN = 256;
  localparam int VW   = VLEN;
  localparam int NB   = VLEN / 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  mem_req_t        req;
  logic            req_store = 1'b0;
  logic [VLEN-1:0] req_wdata = '0;
  logic            mem_valid;
  logic            mem_ready = 1'b0;
  logic [63:0]     mem_addr;
  logic            mem_we;
  logic [63:0]     mem_wdata;
  logic            mem_rvalid = 1'b0;
  logic [63:0]     mem_rdata = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [VLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            busy;

  always #5 clk = ~clk;

  vlsu_sequencer #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .req_store(req_store), .req_wdata(req_wdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t       exp_beats[$];
  logic [63:0] ret_data[$];
  int          ret_dly[$];
  logic [63:0] acc_log[$];
  logic [63:0] stall_log[$];
  bit          active = 0, cur_store = 0, cur_err = 0, pend = 0, resp_seen = 0;
  int          ret_cnt = 0, cyc = 0, acc_cyc = 0, resp_cyc = 0;
  logic [VLEN-1:0] exp_rdata = '0, first_rdata = '0;
  logic        first_err = 1'b0;
  int          rdy_pct = 100, rresp_pct = 100, lat_min = 1, lat_max = 1, spur_pct = 0;
  int          hold_beat = -1, hold_left = 0, rr_hold = 0;
  bit          fixed_data = 0;
  bit          prev_mv = 0, prev_mr = 0, prev_rv = 0, prev_rr = 0, prev_we = 0, prev_err = 0;
  logic [63:0] prev_addr = '0, prev_wd = '0;
  logic [VLEN-1:0] prev_rd = '0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    beat_t b;
    bit    acc_now, hs, all_done;
    int    k;
    @(negedge clk);
    cyc++;
    chk("req_ready", VW'(req_ready), VW'(!active));
    chk("busy", VW'(busy), VW'(active));
    if (prev_mv && !prev_mr) begin
      chk("mem_valid_hold", VW'(mem_valid), VW'(1));
      chk("mem_addr_hold", VW'(mem_addr), VW'(prev_addr));
      chk("mem_we_hold", VW'(mem_we), VW'(prev_we));
      chk("mem_wdata_hold", VW'(mem_wdata), VW'(prev_wd));
    end
    if (mem_valid) begin
      chk("mem_valid_expected", VW'(exp_beats.size() > 0), VW'(1));
`ifndef VLSU_PIPELINED_LOAD_EN
      chk("one_outstanding", VW'(ret_data.size()), VW'(0));
`endif
    end
    if (prev_rv && !prev_rr) begin
      chk("resp_valid_hold", VW'(resp_valid), VW'(1));
      chk("resp_rdata_hold", resp_rdata, prev_rd);
      chk("resp_err_hold", VW'(resp_err), VW'(prev_err));
    end
    if (resp_valid) begin
      all_done = (exp_beats.size() == 0) && (ret_data.size() == 0) &&
                 (cur_store || cur_err || ret_cnt == NB);
      chk("resp_early", VW'(all_done && active), VW'(1));
      chk("resp_rdata", resp_rdata, (cur_store || cur_err) ? '0 : exp_rdata);
      chk("resp_err", VW'(resp_err), VW'(cur_err));
      if (!resp_seen) begin
        resp_seen   = 1;
        resp_cyc    = cyc;
        first_rdata = resp_rdata;
        first_err   = resp_err;
      end
    end

    // Memory return channel: in-order, each return after its programmed delay.
    mem_rvalid = 1'b0;
    mem_rdata  = {$urandom, $urandom};
    if (ret_data.size() > 0) begin
      ret_dly[0] = ret_dly[0] - 1;
      if (ret_dly[0] <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = ret_data[0];
        exp_rdata[64*ret_cnt +: 64] = ret_data[0];
        ret_cnt++;
        void'(ret_data.pop_front());
        void'(ret_dly.pop_front());
      end
    end else if ((!active || cur_store || cur_err || ret_cnt == NB) &&
                 ($urandom_range(99) < spur_pct)) begin
      mem_rvalid = 1'b1;
    end

    mem_ready = ($urandom_range(99) < rdy_pct);
    k = NB - exp_beats.size();
    if (mem_valid && hold_left > 0 && k == hold_beat) begin
      mem_ready = 1'b0;
      hold_left--;
      stall_log.push_back(mem_addr);
    end
    if (mem_valid && mem_ready && exp_beats.size() > 0) begin
      b = exp_beats.pop_front();
      chk("beat_addr", VW'(mem_addr), VW'(b.addr));
      chk("beat_we", VW'(mem_we), VW'(b.we));
      chk("beat_wdata", VW'(mem_wdata), VW'(b.wdata));
      acc_log.push_back(mem_addr);
      if (!b.we) begin
        ret_data.push_back(fixed_data ? (64'hA0 + 64'(k)) : {$urandom, $urandom});
        ret_dly.push_back($urandom_range(lat_max, lat_min));
      end
    end

    resp_ready = ($urandom_range(99) < rresp_pct);
    if (resp_valid && rr_hold > 0) begin
      resp_ready = 1'b0;
      rr_hold--;
    end
    hs = resp_valid && resp_ready;

    req_valid = pend;
    acc_now   = pend && req_ready;
    if (hs) active = 0;
    if (acc_now) begin
      pend      = 0;
      active    = 1;
      cur_store = req_store;
      cur_err   = (req.acc != UNIT_STRIDE);
      exp_beats.delete();
      acc_log.delete();
      stall_log.delete();
      if (!cur_err) begin
        for (int j = 0; j < NB; j++) begin
          b.addr  = req.base + 64'(8 * j);
          b.we    = req_store;
          b.wdata = req_store ? req_wdata[64*j +: 64] : 64'd0;
          exp_beats.push_back(b);
        end
      end
      exp_rdata = '0;
      ret_cnt   = 0;
      acc_cyc   = cyc;
      resp_seen = 0;
    end

    prev_mv = mem_valid;  prev_mr = mem_ready;  prev_addr = mem_addr;
    prev_we = mem_we;     prev_wd = mem_wdata;
    prev_rv = resp_valid; prev_rr = resp_ready; prev_rd = resp_rdata; prev_err = resp_err;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (active && g < 2000) begin
      step();
      g++;
    end
    chk("done_timeout", VW'(active), VW'(0));
  endtask

  task automatic run_req(input logic [63:0] base, input access_e acc, input bit st, input bit wait_done);
    int g;
    req.base  = base;
    req.acc   = acc;
    req_store = st;
    for (int j = 0; j < NB; j++) req_wdata[64*j +: 64] = {$urandom, $urandom};
    pend = 1;
    g = 0;
    while (pend && g < 2000) begin
      step();
      g++;
    end
    chk("accept_timeout", VW'(pend), VW'(0));
    pend = 0;
    if (wait_done) wait_idle();
    else step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, VW'(req_ready), VW'(1));
    chk({tag, "_mem_valid"}, VW'(mem_valid), VW'(0));
    chk({tag, "_mem_we"}, VW'(mem_we), VW'(0));
    chk({tag, "_mem_addr"}, VW'(mem_addr), VW'(0));
    chk({tag, "_mem_wdata"}, VW'(mem_wdata), VW'(0));
    chk({tag, "_resp_valid"}, VW'(resp_valid), VW'(0));
    chk({tag, "_resp_rdata"}, resp_rdata, '0);
    chk({tag, "_resp_err"}, VW'(resp_err), VW'(0));
    chk({tag, "_busy"}, VW'(busy), VW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] lit;
    req.base = '0;
    req.acc  = UNIT_STRIDE;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Store at 0x1000, ready high.
    run_req(64'h1000, UNIT_STRIDE, 1'b1, 1'b1);
    chk("st_beats", VW'(acc_log.size()), VW'(4));
    chk("st_a0", VW'(acc_log[0]), VW'(64'h1000));
    chk("st_a1", VW'(acc_log[1]), VW'(64'h1008));
    chk("st_a2", VW'(acc_log[2]), VW'(64'h1010));
    chk("st_a3", VW'(acc_log[3]), VW'(64'h1018));
    chk("st_latency", VW'(resp_cyc - acc_cyc), VW'(5));
    chk("st_err", VW'(first_err), VW'(0));

    // Load at 0x2000 with data 0xA0+k, one-cycle return.
    fixed_data = 1;
    run_req(64'h2000, UNIT_STRIDE, 1'b0, 1'b1);
    lit = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    chk("ld_rdata_lit", first_rdata, lit);
`ifdef VLSU_PIPELINED_LOAD_EN
    chk("ld_latency", VW'(resp_cyc - acc_cyc), VW'(6));
`else
    chk("ld_latency", VW'(resp_cyc - acc_cyc), VW'(9));
`endif

    // Beat 1 stalled for three cycles.
    hold_beat = 1;
    hold_left = 3;
    run_req(64'h2000, UNIT_STRIDE, 1'b0, 1'b1);
    chk("stall_count", VW'(stall_log.size()), VW'(3));
    for (int j = 0; j < 3; j++) chk("stall_addr", VW'(stall_log[j]), VW'(64'h2008));
    chk("stall_beats", VW'(acc_log.size()), VW'(4));
    for (int j = 0; j < 4; j++) chk("stall_seq", VW'(acc_log[j]), VW'(64'h2000 + 64'(8 * j)));
    chk("stall_rdata_lit", first_rdata, lit);
    hold_beat = -1;
    fixed_data = 0;

    // Unsupported access type.
    run_req(64'h3000, STRIDED, 1'b0, 1'b1);
    chk("err_latency", VW'(resp_cyc - acc_cyc), VW'(1));
    chk("err_flag", VW'(first_err), VW'(1));
    chk("err_rdata", first_rdata, '0);
    chk("err_no_beats", VW'(acc_log.size()), VW'(0));

    // Response held off for four cycles while the next request waits.
    rr_hold = 4;
    run_req(64'h4000, UNIT_STRIDE, 1'b1, 1'b0);
    run_req(64'h5000, UNIT_STRIDE, 1'b0, 1'b1);
    chk("b2b_beats", VW'(acc_log.size()), VW'(4));

    // Randomized traffic.
    spur_pct = 30;
    for (int n = 0; n < 40; n++) begin
      rdy_pct   = $urandom_range(100, 30);
      rresp_pct = $urandom_range(100, 30);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      run_req({$urandom, $urandom} & ~64'h7,
              ($urandom_range(7) < 6) ? UNIT_STRIDE : access_e'($urandom_range(3, 1)),
              1'(($urandom_range(1))), 1'(($urandom_range(1))));
    end
    wait_idle();

    // Asynchronous reset while waiting on load data.
    spur_pct = 0; rdy_pct = 100; rresp_pct = 100; lat_min = 8; lat_max = 8;
    run_req(64'h6000, UNIT_STRIDE, 1'b0, 1'b0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    mem_rvalid = 1'b0; mem_ready = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
    active = 0; pend = 0; prev_mv = 0; prev_rv = 0;
    exp_beats.delete(); ret_data.delete(); ret_dly.delete();
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_rst");
    rst_n = 1'b1;
    lat_min = 1; lat_max = 1; fixed_data = 1;
    run_req(64'h2000, UNIT_STRIDE, 1'b0, 1'b1);
    chk("post_rst_beats", VW'(acc_log.size()), VW'(4));
    chk("post_rst_rdata", first_rdata, lit);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vlsu_sequencer.md
# vlsu_sequencer

Vector load/store sequencer that drives the address generation unit and the 64-bit memory port. It accepts one whole-register memory request at a time and latches it. It walks the `VLEN/64` beat addresses produced by `agu`, issuing one 64-bit memory transaction per beat. It then returns a single assembled `VLEN`-bit response to the vector datapath. It sits between the vector issue stage and the memory interface.

## Interface
- `NBEAT`, default `VLEN/64`: beats per request; must equal the `agu` address-array depth; minimum 1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request offered.
- `req_ready`  out  1: high only in IDLE.
- `req`  in  `mem_req_t`: base address and access type.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_wdata`  in  VLEN: store data; beat k = bits [64k+63:64k].
- `mem_valid`  out  1: memory transaction valid.
- `mem_ready`  in  1: memory accepts the transaction.
- `mem_addr`  out  64: beat address.
- `mem_we`  out  1: write enable.
- `mem_wdata`  out  64: beat write data.
- `mem_rvalid`  in  1: load data return, in order.
- `mem_rdata`  in  64: load data.
- `resp_valid`  out  1: response valid.
- `resp_ready`  in  1: response accepted.
- `resp_rdata`  out  VLEN: assembled load data; zero for stores and errors.
- `resp_err`  out  1: unsupported access type.
- `busy`  out  1: state is not IDLE.

## Operation
- States:
  - IDLE: request is accepted on `req_valid && req_ready`.
  - ISSUE: beat transactions are issued.
  - WAIT: load data is collected.
  - RESP: response is presented.
- On acceptance, latch `req`, `req_store` and `req_wdata`. Clear the issue counter `ibeat`, the return counter `rbeat`, and the data buffer.
- The latched request feeds an internal `agu` instance. `mem_addr` = `addresses[ibeat]`.
- Unsupported access type (anything other than UNIT_STRIDE): go IDLE→RESP directly. Set `resp_err`=1 and `resp_rdata`=0. No memory traffic occurs.
- ISSUE:
  - `mem_valid`=1 and `mem_we`=latched store.
  - `mem_wdata` = store beat `ibeat`; 0 for loads.
  - On `mem_valid && mem_ready`: `ibeat` increments.
- Store: after beat NBEAT-1 is accepted, go ISSUE→RESP. `rbeat` is unused.
- Load, non-pipelined: after each accepted beat go ISSUE→WAIT. In WAIT, on `mem_rvalid`, write `mem_rdata` into slot `rbeat` and increment `rbeat`. Return to ISSUE, or go to RESP if `rbeat` reaches NBEAT.
- RESP: `resp_valid`=1 until `resp_ready`, then go to IDLE. Response outputs are held stable while `resp_valid && !resp_ready`.
- `mem_rvalid` outside an expected window (IDLE, RESP, store, or `rbeat`=NBEAT) is ignored.
- Counters are `$clog2(NBEAT)+1` bits wide. Beat slots are indexed modulo NBEAT; there is no wrap past NBEAT.
- Reset mid-operation aborts the request. The in-flight memory beat is dropped, and the memory side tolerates this.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1 (combinational from IDLE).
  - `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0.
- Acceptance edge t: `mem_valid` rises at t+1.
- Store with `mem_ready` tied high: beats at t+1..t+NBEAT, and `resp_valid` at t+NBEAT+1.
- Load, non-pipelined, with `mem_rvalid` one cycle after acceptance: 2 cycles per beat, so `resp_valid` at t+2·NBEAT+1.
- Error path: `resp_valid` at t+1.
- `mem_addr`, `mem_we` and `mem_wdata` are held stable while `mem_valid && !mem_ready`.
- The next request is accepted no earlier than the cycle after the response handshake.

## Configuration
- `VLSU_PIPELINED_LOAD_EN` defined:
  - Loads stay in ISSUE and issue beats back-to-back, independent of returns.
  - `mem_rvalid` is accepted in both ISSUE and WAIT, with `rbeat` counting independently.
  - After the last issue, go to WAIT until `rbeat`=NBEAT.
  - If `mem_rvalid` and a beat acceptance occur in the same cycle, both counters update.
  - With ready high and 1-cycle return latency, `resp_valid` arrives at t+NBEAT+2.
- Undefined: one outstanding load beat, as described in Operation.

## Test plan
- Store, base 0x1000, NBEAT=4, `mem_ready`=1 → addresses 0x1000/0x1008/0x1010/0x1018, `mem_we`=1 with matching 64-bit slices, `resp_valid` at t+5, `resp_err`=0.
- Load, base 0x2000, `mem_rdata` = 0xA0+k per beat → `resp_rdata` beats = {0xA3,0xA2,0xA1,0xA0} (MSB beat first), correct latency for each macro setting.
- `mem_ready` held low 3 cycles on beat 1 → `mem_addr` holds 0x2008 stable, and no beat is skipped or duplicated.
- Non-UNIT_STRIDE request → no `mem_valid`, `resp_valid` at t+1 with `resp_err`=1 and `resp_rdata`=0.
- `resp_ready` low 4 cycles → response held stable and `req_ready`=0; new request accepted only after the handshake.
- `rst_n` asserted during WAIT → all outputs return to reset values asynchronously, and a fresh request then completes correctly.
